// File: rtl/iddmm_sched.sv
// Row/beat scheduler for a word-serial Montgomery multiplier: issues N rows of
// N+1 operand reads separated by GAP idle cycles. Define IDDMM_SCHED_DRAIN_EN to add a DRAIN phase before done.
module iddmm_sched #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N),
  parameter int GAP    = 30,
  parameter int DRAIN  = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_x_addr,
  output logic [ADDR_W-1:0] rd_yp_addr,
  output logic [ADDR_W:0]   j_cnt,
  output logic              op_zero,
  output logic              a_zero
);

  localparam int CMAX = (GAP > DRAIN) ? GAP : DRAIN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [ADDR_W:0]   J_LAST   = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     GAP_LAST = CW'(GAP - 1);
`ifdef IDDMM_SCHED_DRAIN_EN
  localparam logic [CW-1:0]     DRAIN_LAST = CW'(DRAIN - 1);
`endif

  if (K < 1 || GAP < 1 || DRAIN < 1) begin : g_bad_param
    $error("iddmm_sched: K, GAP and DRAIN must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
`ifdef IDDMM_SCHED_DRAIN_EN
    S_DRAIN,
`endif
    S_FIN
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] i, i_n;
  logic [ADDR_W:0]   j, j_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      i     <= '0;
      j     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_ISSUE;
        i_n     = '0;
        j_n     = '0;
      end
      S_ISSUE: begin
        if (j == J_LAST) begin
          j_n   = '0;
          cnt_n = '0;
          if (i == I_LAST) begin
`ifdef IDDMM_SCHED_DRAIN_EN
            state_n = S_DRAIN;
`else
            state_n = S_FIN;
`endif
          end else begin
            i_n     = i + ADDR_W'(1);
            state_n = S_GAP;
          end
        end else begin
          j_n = j + (ADDR_W+1)'(1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = S_ISSUE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef IDDMM_SCHED_DRAIN_EN
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_n   = '0;
          state_n = S_FIN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      // i returns to 0 here so the x address reads 0 while idle
      S_FIN: begin
        state_n = S_IDLE;
        i_n     = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign issue      = (state == S_ISSUE);
  assign rd_en      = issue;
  assign busy       = (state != S_IDLE) && (state != S_FIN);
  assign done       = (state == S_FIN);
  assign rd_x_addr  = i;
  assign rd_yp_addr = (issue && j != J_LAST) ? j[ADDR_W-1:0] : '0;

  // Beat tags lag rd_en by one cycle to line up with the RAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_cnt   <= '0;
      op_zero <= 1'b0;
      a_zero  <= 1'b0;
    end else begin
      j_cnt   <= issue ? j : '0;
      op_zero <= issue && (j == J_LAST);
      a_zero  <= issue && (i == '0);
    end
  end

endmodule

// File: tb/tb_iddmm_sched.sv
// Self-checking bench for iddmm_sched at N=4, GAP=2: table vectors, reset
// corner cases, and randomized jobs against a cycle-index arithmetic model.
module tb_iddmm_sched;
  localparam int N     = 4;
  localparam int GAP   = 2;
  localparam int DRAIN = 29;
  localparam int AW    = 2;
  localparam int P     = N + 1 + GAP;
  localparam int LAST  = (N - 1) * P + N;
`ifdef IDDMM_SCHED_DRAIN_EN
  localparam int KFIN  = LAST + 1 + DRAIN;
`else
  localparam int KFIN  = LAST + 1;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          busy, done, rd_en, op_zero, a_zero;
  logic [AW-1:0] rd_x_addr, rd_yp_addr;
  logic [AW:0]   j_cnt;

  iddmm_sched #(.K(128), .N(N), .ADDR_W(AW), .GAP(GAP), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_x_addr(rd_x_addr), .rd_yp_addr(rd_yp_addr),
    .j_cnt(j_cnt), .op_zero(op_zero), .a_zero(a_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] x;
    logic [AW-1:0] yp;
    logic [AW:0]   jc;
    logic          opz;
    logic          az;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    int   k;
    obs_t e;
  } vec_t;

  obs_t act;
  assign act = {rd_en, rd_x_addr, rd_yp_addr, j_cnt, op_zero, a_zero, busy, done};

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[12];

  function automatic obs_t mk(int r, int x, int yp, int jc, int oz, int az, int b, int d);
    obs_t o;
    o.rd_en = r[0]; o.x = AW'(x); o.yp = AW'(yp); o.jc = (AW+1)'(jc);
    o.opz = oz[0]; o.az = az[0]; o.busy = b[0]; o.done = d[0];
    return o;
  endfunction

  // k = cycles since the edge that accepted start; k<0 or past done is idle
  function automatic obs_t model(int k);
    obs_t o = '0;
    int row, pos, prow, ppos;
    if (k < 0 || k > KFIN) return o;
    if (k <= LAST) begin
      row = k / P;
      pos = k % P;
      if (pos <= N) begin
        o.rd_en = 1'b1;
        o.x     = AW'(row);
        o.yp    = (pos == N) ? '0 : AW'(pos);
      end else begin
        o.x = AW'(row + 1);
      end
    end else begin
      o.x = AW'(N - 1);
    end
    o.busy = (k < KFIN);
    o.done = (k == KFIN);
    if (k >= 1 && k - 1 <= LAST) begin
      prow = (k - 1) / P;
      ppos = (k - 1) % P;
      if (ppos <= N) begin
        o.jc  = (AW+1)'(ppos);
        o.opz = (ppos == N);
        o.az  = (prow == 0);
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int k, input obs_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", nm, k, act, e);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // use_tbl: compare only at table points; stray: random ignored start pulses,
  // always including one in the done cycle
  task automatic run_job(input bit use_tbl, input bit stray);
    int beats = 0;
    int dones = 0;
    do_start();
    for (int k = 0; k <= KFIN + 1; k++) begin
      if (k > 0) begin
        tick();
        start = 1'b0;
      end
      if (use_tbl) begin
        foreach (tbl[t]) if (tbl[t].k == k) chk("tbl", k, tbl[t].e);
      end else begin
        chk("model", k, model(k));
      end
      beats += int'(rd_en);
      dones += int'(done);
      if (stray && k <= KFIN) start = (k == KFIN) || ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk_int("beats", beats, N * (N + 1));
    chk_int("dones", dones, 1);
    tick();
    chk("post_idle", KFIN + 2, model(KFIN + 2));
  endtask

  initial begin
    tbl[0]  = '{0,  mk(1,0,0,0,0,0,1,0)};
    tbl[1]  = '{1,  mk(1,0,1,0,0,1,1,0)};
    tbl[2]  = '{4,  mk(1,0,0,3,0,1,1,0)};
    tbl[3]  = '{5,  mk(0,1,0,4,1,1,1,0)};
    tbl[4]  = '{6,  mk(0,1,0,0,0,0,1,0)};
    tbl[5]  = '{7,  mk(1,1,0,0,0,0,1,0)};
    tbl[6]  = '{8,  mk(1,1,1,0,0,0,1,0)};
    tbl[7]  = '{12, mk(0,2,0,4,1,0,1,0)};
    tbl[8]  = '{25, mk(1,3,0,3,0,0,1,0)};
`ifdef IDDMM_SCHED_DRAIN_EN
    tbl[9]  = '{26, mk(0,3,0,4,1,0,1,0)};
    tbl[10] = '{55, mk(0,3,0,0,0,0,0,1)};
    tbl[11] = '{56, mk(0,0,0,0,0,0,0,0)};
`else
    tbl[9]  = '{26, mk(0,3,0,4,1,0,0,1)};
    tbl[10] = '{27, mk(0,0,0,0,0,0,0,0)};
    tbl[11] = '{28, mk(0,0,0,0,0,0,0,0)};
`endif

    #12;
    chk("reset", -1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle", -1, '0);

    run_job(1'b1, 1'b0);
    run_job(1'b0, 1'b1);

    // Reset in the middle of row 1 abandons the job immediately
    do_start();
    for (int k = 0; k <= P + 2; k++) begin
      if (k > 0) tick();
      chk("pre_rst", k, model(k));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", -1, '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_hold", -1, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_idle", -1, '0);
    end
    run_job(1'b0, 1'b0);

    for (int n = 0; n < 5; n++) begin
      int idle = $urandom_range(0, 4);
      for (int c = 0; c < idle; c++) begin
        tick();
        chk("rand_idle", -1, '0);
      end
      run_job(1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iddmm_sched.md
IDDMM_SCHED -- requirements
Module: iddmm_sched

Interface
REQ-001 Parameter K, default 128: bits per operand word; passed through for width consistency only.
REQ-002 Parameter N, default 32: number of words per operand.
REQ-003 Parameter ADDR_W, default $clog2(N): word-address width.
REQ-004 Parameter GAP, default 30: idle cycles between the last beat of one row and the first beat of the next; must be at least the downstream writeback latency (28) plus the RAM read latency (1) plus 1.
REQ-005 Parameter DRAIN, default 29: cycles from the final issued beat to the final write-back of the downstream calculator.
REQ-006 clk  input  1  clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  one-cycle request to begin one Montgomery multiplication.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done is high.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rd_en  output  1  operand-RAM read strobe, high on every issue beat.
REQ-012 rd_x_addr  output  ADDR_W  x word index, equal to the current row i.
REQ-013 rd_yp_addr  output  ADDR_W  y/p/a word index, equal to the current beat j; 0 when j==N.
REQ-014 j_cnt  output  ADDR_W+1  beat tag to the calculator; registered one cycle after rd_en, aligned with RAM data.
REQ-015 op_zero  output  1  aligned with j_cnt; high when the y/p/a words must be forced to 0 (j==N).
REQ-016 a_zero  output  1  aligned with j_cnt; high during row 0, forcing the accumulator word a to 0.

Function
REQ-017 The state machine SHALL have the states IDLE, ISSUE, GAP, DRAIN and FIN.
REQ-018 IDLE: start==1 -> ISSUE with i=0 and j=0, and busy rises on the next cycle; start in any other state is ignored.
REQ-019 ISSUE: one beat per cycle, with rd_en=1 and j incrementing 0..N, giving N+1 contiguous beats per row with no bubble inside a row.
REQ-020 ISSUE at j==N: if i<N-1, the block SHALL go to GAP with i incremented; if i==N-1, it SHALL go to DRAIN (macro on) or FIN (macro off).
REQ-021 GAP: the block SHALL count exactly GAP cycles with rd_en=0, then return to ISSUE with j=0.
REQ-022 DRAIN: the block SHALL count exactly DRAIN cycles, then go to FIN.
REQ-023 FIN: the block SHALL assert done=1 for one cycle and return to IDLE, with busy=0 in that same cycle.
REQ-024 j_cnt SHALL be 0 on every non-issue cycle, including IDLE and GAP.
REQ-025 op_zero and a_zero SHALL be 0 on every non-issue-aligned cycle.
REQ-026 Row period SHALL be N+1+GAP cycles, and total issue beats SHALL be N*(N+1).
REQ-027 rd_x_addr SHALL hold i in every state except IDLE, where it is 0; rd_yp_addr SHALL be 0 when rd_en=0.
REQ-028 A start arriving in the same cycle as done SHALL be ignored; the earliest accepted start is the cycle after done.
REQ-029 Counter widths: i uses ADDR_W bits, j uses ADDR_W+1 bits, and the gap/drain counter uses $clog2(max(GAP,DRAIN)+1) bits; no counter SHALL wrap.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, clear i, j and all counters, and drive busy, done, rd_en, j_cnt, op_zero and a_zero to 0 and both addresses to 0.
REQ-031 Reset asserted mid-operation SHALL abandon the job with no done pulse; after release the block sits in IDLE until a new start.

Configuration
REQ-032 Macro IDDMM_SCHED_DRAIN_EN defined: the last row SHALL pass through DRAIN, so done fires DRAIN+1 cycles after the final beat and all results are written back.
REQ-033 Macro IDDMM_SCHED_DRAIN_EN undefined: the DRAIN state SHALL be removed, and done fires one cycle after the final beat.

Verification
REQ-034 N=4, GAP=2, macro off: start pulse -> rows of 5 beats with j_cnt 0,1,2,3,4; 2-cycle gaps; 20 beats total; done exactly once.
REQ-035 N=4, GAP=2: during row 0, a_zero=1 on all 5 beats; op_zero=1 only on the j_cnt==4 beats of every row; both are 0 otherwise.
REQ-036 N=4, GAP=2, DRAIN=29, macro on: done occurs 30 cycles after the last rd_en; busy stays high throughout.
REQ-037 start pulsed again during row 2 -> no restart and beat sequence unchanged; start coincident with done -> stays IDLE.
REQ-038 rst_n low in the middle of row 1 -> all outputs are 0 within the same cycle, with no done; a new start after release -> the full sequence is correct.
REQ-039 Default parameters, integrated with the calculator and random 4096-bit x, y, p: the result RAM SHALL equal x*y*R^-1 mod p (before any final subtraction) against the reference model.
